// File: rtl/freq_monitor_pkg.sv
// Shared types and helpers for the pixel frequency monitor.
// Latency: n/a (types, constants and elaboration-time functions only).
// Backpressure: n/a.
package freq_monitor_pkg;

    // Measurement controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DUMP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Operation code axi_slave_impl associates with each reg_number/reg_data beat
    localparam int REG_WRITE_OPERATION = 2;

    // Period counter and hit counter widths
    localparam int PERIOD_WIDTH = 32;
    localparam int HIT_WIDTH    = 32;

    // Shortest accepted period (clocks) for a window centred on f_hz
    function automatic logic [31:0] period_min(input logic [31:0] clk_hz,
                                               input logic [31:0] f_hz,
                                               input logic [31:0] dev_hz);
        return clk_hz / (f_hz + dev_hz);
    endfunction

    // Longest accepted period (clocks) for a window centred on f_hz
    function automatic logic [31:0] period_max(input logic [31:0] clk_hz,
                                               input logic [31:0] f_hz,
                                               input logic [31:0] dev_hz);
        return clk_hz / (f_hz - dev_hz);
    endfunction

endpackage

// File: rtl/freq_channel_meter.sv
// One monitored pixel: latches its thresholded bit, times rising edges, counts periods in two windows.
// Latency: sample visible 1 clock after latch, edge scored 1 clock later; hit counters update on that edge.
// Backpressure: none; all activity gated by run, restart zeroes counters and disarms.
module freq_channel_meter
    import freq_monitor_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 100000000,
    parameter int unsigned F0              = 5000,
    parameter int unsigned F1              = 10000,
    parameter int unsigned DEV             = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 restart,
    input  logic                 sample_en,
    input  logic                 sample_bit,
    output logic [HIT_WIDTH-1:0] hits0,
    output logic [HIT_WIDTH-1:0] hits1
);

    localparam logic [PERIOD_WIDTH-1:0] P0_MIN = period_min(CLOCK_FREQUENCY, F0, DEV);
    localparam logic [PERIOD_WIDTH-1:0] P0_MAX = period_max(CLOCK_FREQUENCY, F0, DEV);
    localparam logic [PERIOD_WIDTH-1:0] P1_MIN = period_min(CLOCK_FREQUENCY, F1, DEV);
    localparam logic [PERIOD_WIDTH-1:0] P1_MAX = period_max(CLOCK_FREQUENCY, F1, DEV);

    logic                    sample;
    logic                    sample_prev;
    logic                    armed;
    logic [PERIOD_WIDTH-1:0] period;
    logic                    rise;
    logic                    period_sat;
    logic                    in_win0;
    logic                    in_win1;

    assign rise       = run && sample && !sample_prev;
    assign period_sat = &period;
    // A saturated period means "too long to know", so it never scores
    assign in_win0    = !period_sat && (period >= P0_MIN) && (period <= P0_MAX);
    assign in_win1    = !period_sat && (period >= P1_MIN) && (period <= P1_MAX);

    // Latch the pixel bit when its index goes by; keep the previous value for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample      <= 1'b0;
            sample_prev <= 1'b0;
        end else if (run) begin
            if (sample_en) begin
                sample <= sample_bit;
            end
            sample_prev <= sample;
        end
    end

    // Period timer: edge cycle counts as 1, saturates; first edge after restart only arms
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period <= '0;
            armed  <= 1'b0;
        end else if (restart) begin
            period <= '0;
            armed  <= 1'b0;
        end else if (run) begin
            if (rise) begin
                period <= {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
                armed  <= 1'b1;
            end else if (!period_sat) begin
                period <= period + 1'b1;
            end
        end
    end

    // Saturating hit counters, both may step on the same edge when windows overlap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits0 <= '0;
            hits1 <= '0;
        end else if (restart) begin
            hits0 <= '0;
            hits1 <= '0;
        end else if (rise && armed) begin
            if (in_win0 && !(&hits0)) begin
                hits0 <= hits0 + 1'b1;
            end
            if (in_win1 && !(&hits1)) begin
                hits1 <= hits1 + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_frequency_monitor.sv
// N-channel pixel frequency monitor; dumps hit counters as numbered register writes then raises irq.
// Latency: first register 1 clock after entering DUMP; irq 1 clock after the last accepted register.
// Backpressure: reg_number/reg_data held while reg_valid && !reg_ready. FREQ_MONITOR_TIMESTAMP_EN adds a RUN-clock register.
module pixel_frequency_monitor
    import freq_monitor_pkg::*;
#(
    parameter int                              CHANNELS            = 3,
    parameter int                              DATA_WIDTH          = 8,
    parameter int                              THRESHOLD           = 192,
    parameter int                              PIX_CNT_WIDTH       = 16,
    parameter logic [CHANNELS*PIX_CNT_WIDTH-1:0] PIXEL_INDICES     = {16'd1023, 16'd511, 16'd63},
    parameter logic [CHANNELS*32-1:0]          FREQ0_LIST          = {32'd25000, 32'd15000, 32'd5000},
    parameter logic [CHANNELS*32-1:0]          FREQ1_LIST          = {32'd30000, 32'd20000, 32'd10000},
    parameter int unsigned                     FREQUENCY_DEVIATION = 20,
    parameter int unsigned                     CLOCK_FREQUENCY     = 100000000
) (
    input  logic                  s00_axi_aclk,
    input  logic                  s00_axi_aresetn,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  pixel_valid,
    input  logic                  frame_start,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    output logic                  reg_valid,
    input  logic                  reg_ready,
    output logic [7:0]            reg_number,
    output logic [31:0]           reg_data,
    output logic                  busy,
    output logic                  irq
);

    localparam logic [DATA_WIDTH-1:0] THRESH = DATA_WIDTH'(THRESHOLD);
`ifdef FREQ_MONITOR_TIMESTAMP_EN
    localparam logic [7:0] LAST_REG = 8'(2*CHANNELS + 1);
`else
    localparam logic [7:0] LAST_REG = 8'(2*CHANNELS);
`endif

    state_t                   state;
    state_t                   state_next;
    logic                     start_go;
    logic                     restart;
    logic                     run;
    logic                     sample_bit;
    logic [PIX_CNT_WIDTH-1:0] pix_cnt;
    logic [PIX_CNT_WIDTH-1:0] pix_idx_next;
    logic [HIT_WIDTH-1:0]     hits0 [CHANNELS];
    logic [HIT_WIDTH-1:0]     hits1 [CHANNELS];
    logic [7:0]               dump_num;
    logic [31:0]              dump_data;

    assign run          = (state == ST_RUN);
    assign restart      = clear || start_go;
    assign busy         = (state == ST_RUN) || (state == ST_DUMP);
    assign irq          = (state == ST_DONE);
    assign sample_bit   = (data >= THRESH);
    assign pix_idx_next = frame_start ? '0 : pix_cnt + 1'b1;

    // Pixel index within the frame; the current pixel's index is pix_idx_next
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            pix_cnt <= '0;
        end else if (pixel_valid) begin
            pix_cnt <= pix_idx_next;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        freq_channel_meter #(
            .CLOCK_FREQUENCY (CLOCK_FREQUENCY),
            .F0              (FREQ0_LIST[c*32 +: 32]),
            .F1              (FREQ1_LIST[c*32 +: 32]),
            .DEV             (FREQUENCY_DEVIATION)
        ) u_meter (
            .clk        (s00_axi_aclk),
            .rst_n      (s00_axi_aresetn),
            .run        (run),
            .restart    (restart),
            .sample_en  (pixel_valid && (pix_idx_next == PIXEL_INDICES[c*PIX_CNT_WIDTH +: PIX_CNT_WIDTH])),
            .sample_bit (sample_bit),
            .hits0      (hits0[c]),
            .hits1      (hits1[c])
        );
    end

`ifdef FREQ_MONITOR_TIMESTAMP_EN
    logic [31:0] run_cnt;

    // Clocks spent in RUN, saturating
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            run_cnt <= '0;
        end else if (restart) begin
            run_cnt <= '0;
        end else if (run && !(&run_cnt)) begin
            run_cnt <= run_cnt + 1'b1;
        end
    end
`endif

    // State register
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: clear dominates, start only honoured from IDLE/DONE, stop only from RUN
    always_comb begin
        state_next = state;
        start_go   = 1'b0;
        if (clear) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_next = ST_RUN;
                        start_go   = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_next = ST_DUMP;
                    end
                end
                ST_DUMP: begin
                    if (reg_valid && reg_ready && (reg_number == LAST_REG)) begin
                        state_next = ST_DONE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Register that would be presented next: odd numbers are F0 hits, even are F1 hits
    always_comb begin
        dump_num  = reg_valid ? (reg_number + 8'd1) : 8'd1;
        dump_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (dump_num == 8'(2*c + 1)) begin
                dump_data = hits0[c];
            end
            if (dump_num == 8'(2*c + 2)) begin
                dump_data = hits1[c];
            end
        end
`ifdef FREQ_MONITOR_TIMESTAMP_EN
        if (dump_num == 8'(2*CHANNELS + 1)) begin
            dump_data = run_cnt;
        end
`endif
    end

    // Dump output stage: load first register on DUMP entry, advance on each accepted transfer
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            reg_valid  <= 1'b0;
            reg_number <= '0;
            reg_data   <= '0;
        end else if (clear) begin
            reg_valid  <= 1'b0;
            reg_number <= '0;
            reg_data   <= '0;
        end else if (state == ST_DUMP) begin
            if (!reg_valid) begin
                reg_valid  <= 1'b1;
                reg_number <= dump_num;
                reg_data   <= dump_data;
            end else if (reg_ready) begin
                if (reg_number == LAST_REG) begin
                    reg_valid <= 1'b0;
                end else begin
                    reg_number <= dump_num;
                    reg_data   <= dump_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_frequency_monitor.sv
// Directed bench for pixel_frequency_monitor at 1 MHz, all channels on pixel 0.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: reg_ready driven by the dump collector, stalled on request.
module tb_pixel_frequency_monitor;

`ifdef FREQ_MONITOR_TIMESTAMP_EN
    localparam int NREG = 7;
`else
    localparam int NREG = 6;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data;
    logic        pixel_valid;
    logic        frame_start;
    logic        start;
    logic        stop;
    logic        clear;
    logic        reg_valid;
    logic        reg_ready;
    logic [7:0]  reg_number;
    logic [31:0] reg_data;
    logic        busy;
    logic        irq;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] got [0:15];

    always #5 clk = ~clk;

    pixel_frequency_monitor #(
        .CLOCK_FREQUENCY (1000000),
        .PIXEL_INDICES   ('0)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .data            (data),
        .pixel_valid     (pixel_valid),
        .frame_start     (frame_start),
        .start           (start),
        .stop            (stop),
        .clear           (clear),
        .reg_valid       (reg_valid),
        .reg_ready       (reg_ready),
        .reg_number      (reg_number),
        .reg_data        (reg_data),
        .busy            (busy),
        .irq             (irq)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic square(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            data = 8'd255;
            repeat (hi) step();
            data = 8'd0;
            repeat (lo) step();
        end
    endtask

    task automatic wait_reg(input int n);
        int g;
        g = 0;
        while (!(reg_valid && reg_number == 8'(n)) && g < 100) begin
            step();
            g++;
        end
        chk($sformatf("wait_reg%0d", n), 32'(reg_valid && reg_number == 8'(n)), 1);
    endtask

    // Reads a whole dump into got[], optionally stalling 5 cycles on one register
    task automatic collect(input int stall_at);
        int          n;
        int          guard;
        logic [31:0] held;
        n         = 1;
        guard     = 0;
        reg_ready = 1'b1;
        for (int i = 0; i < 16; i++) got[i] = 32'hdead_beef;
        while (n <= NREG && guard < 200) begin
            if (reg_valid) begin
                chk("reg_number", 32'(reg_number), n);
                if (n == stall_at) begin
                    held      = reg_data;
                    reg_ready = 1'b0;
                    repeat (5) begin
                        step();
                        chk("stall_vld", 32'(reg_valid), 1);
                        chk("stall_num", 32'(reg_number), n);
                        chk("stall_dat", reg_data, held);
                    end
                    reg_ready = 1'b1;
                end
                if (n == NREG) chk("irq_before_last", 32'(irq), 0);
                got[n] = reg_data;
                n++;
            end
            step();
            guard++;
        end
        chk("dump_len", n - 1, NREG);
        chk("vld_after_dump", 32'(reg_valid), 0);
        chk("irq_after_dump", 32'(irq), 1);
    endtask

    task automatic check_regs(input string tag, input logic [31:0] r1, input logic [31:0] r2);
        for (int n = 1; n <= 6; n++) begin
            chk($sformatf("%s_reg%0d", tag, n), got[n], (n == 1) ? r1 : (n == 2) ? r2 : 32'd0);
        end
    endtask

    initial begin
        data        = 8'd0;
        pixel_valid = 1'b1;
        frame_start = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        clear       = 1'b0;
        reg_ready   = 1'b1;

        // Reset values
        repeat (3) step();
        chk("rst_vld", 32'(reg_valid), 0);
        chk("rst_num", 32'(reg_number), 0);
        chk("rst_dat", reg_data, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_irq", 32'(irq), 0);
        rst_n = 1'b1;
        step();

        // 1: 200-clock period on ch0 hits F0 window 199..200, 11 edges -> 10 hits
        pulse_start();
        chk("t1_busy", 32'(busy), 1);
        square(100, 100, 11);
        pulse_stop();
        chk("t1_vld_entry", 32'(reg_valid), 0);
        collect(0);
        check_regs("t1", 10, 0);

        // 2+3: 100-clock period hits F1 window 99..100; stall on reg3
        pulse_start();
        chk("t2_irq_cleared", 32'(irq), 0);
        square(50, 50, 6);
        pulse_stop();
        collect(3);
        check_regs("t2", 0, 5);

        // 4: clear mid-dump after reg2, then a fresh run counts from zero
        pulse_start();
        square(100, 100, 3);
        pulse_stop();
        wait_reg(3);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t4_vld_clear", 32'(reg_valid), 0);
        chk("t4_irq_clear", 32'(irq), 0);
        chk("t4_busy_clear", 32'(busy), 0);
        repeat (3) step();
        chk("t4_irq_later", 32'(irq), 0);
        chk("t4_idle", 32'(busy), 0);
        pulse_start();
        square(100, 100, 2);
        pulse_stop();
        collect(0);
        check_regs("t4", 1, 0);

        // 5: start+stop together in IDLE -> RUN, in RUN -> DUMP; 5000-clock period never hits
        clear = 1'b1;
        step();
        clear = 1'b0;
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        step();
        chk("t5_run_busy", 32'(busy), 1);
        chk("t5_run_novld", 32'(reg_valid), 0);
        square(2500, 2500, 2);
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("t5_dump_busy", 32'(busy), 1);
        collect(0);
        check_regs("t5", 0, 0);

`ifdef FREQ_MONITOR_TIMESTAMP_EN
        // 6: exactly 1000 RUN clocks reported as reg7
        pulse_start();
        repeat (999) step();
        pulse_stop();
        collect(0);
        chk("t6_reg7", got[7], 1000);
`endif

        // Async reset mid-dump returns to reset values with no irq
        pulse_start();
        square(100, 100, 2);
        pulse_stop();
        wait_reg(2);
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(reg_valid), 0);
        chk("arst_num", 32'(reg_number), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_irq", 32'(irq), 0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("arst_irq_later", 32'(irq), 0);
        chk("arst_busy_later", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
